// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control slice: opcodes, FSM state encoding
// and the opcode to unit-enable decode.
package alu_pkg;

   localparam logic [1:0] OP_SUMA  = 2'b00;
   localparam logic [1:0] OP_RESTA = 2'b01;
   localparam logic [1:0] OP_AND   = 2'b10;
   localparam logic [1:0] OP_OR    = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StEspera,
      StResp
   } state_e;

   function automatic logic [3:0] op_onehot(input logic [1:0] op);
      logic [3:0] oh;
      oh = 4'b0000;
      unique case (op)
         OP_SUMA:  oh = 4'b0001;
         OP_RESTA: oh = 4'b0010;
         OP_AND:   oh = 4'b0100;
         OP_OR:    oh = 4'b1000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/control_alu_if.sv
// Bundle of the two request channels, the unit operand/enable/result bus and
// the response channel of control_alu.
interface control_alu_if #(
   parameter int unsigned W = 4
);

   logic         req0_valid;
   logic         req0_ready;
   logic [1:0]   req0_op;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;

   logic         req1_valid;
   logic         req1_ready;
   logic [1:0]   req1_op;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;

   logic [W-1:0] reg0;
   logic [W-1:0] reg1;
   logic [3:0]   en_unidad;
   logic [W-1:0] ans_suma;
   logic [W-1:0] ans_resta;
   logic [W-1:0] ans_and;
   logic [W-1:0] ans_or;

   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] resp_dato;
   logic         resp_id;
   logic         resp_cero;

   // Controller side.
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output reg0, reg1, en_unidad,
      input  ans_suma, ans_resta, ans_and, ans_or,
      output resp_valid, resp_dato, resp_id, resp_cero,
      input  resp_ready
   );

   // Requesters, units and response consumer side.
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  reg0, reg1, en_unidad,
      output ans_suma, ans_resta, ans_and, ans_or,
      input  resp_valid, resp_dato, resp_id, resp_cero,
      output resp_ready
   );

endinterface

// File: rtl/arbitro_rr.sv
// Two-way round-robin grant: a lone requester wins, on contention the one that
// was not served last wins.
module arbitro_rr (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       ultimo,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant_id = 1'b0;
      if (valid0 && valid1) begin
         grant_id = ~ultimo;
      end else if (valid1) begin
         grant_id = 1'b1;
      end
      grant = 2'b00;
      if (valid0 || valid1) begin
         grant = grant_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/control_alu.sv
// Sequencer in front of the registered ALU units: arbitrates two requesters,
// drives operands and a one-hot enable, waits LAT cycles and returns the result.
module control_alu
   import alu_pkg::*;
#(
   parameter int unsigned W   = 4,
   parameter int unsigned LAT = 1
) (
   input logic          clk,
   input logic          rst,
   control_alu_if.slave bus
);

   localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

   state_e          state_q, state_d;
   logic            ultimo_q, ultimo_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    reg0_q, reg0_d;
   logic [W-1:0]    reg1_q, reg1_d;
   logic [1:0]      op_q, op_d;
   logic            id_q, id_d;
   logic            resp_valid_q, resp_valid_d;
   logic [W-1:0]    resp_dato_q, resp_dato_d;
   logic            resp_id_q, resp_id_d;
   logic            resp_cero_q, resp_cero_d;

   logic [1:0]      grant;
   logic            grant_id;
   logic [W-1:0]    ans_sel;
   logic            req0_ready, req1_ready;
   logic [3:0]      en_unidad;

   arbitro_rr u_arbitro (
      .valid0   (bus.req0_valid),
      .valid1   (bus.req1_valid),
      .ultimo   (ultimo_q),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_comb begin
      ans_sel = bus.ans_suma;
      unique case (op_q)
         OP_SUMA:  ans_sel = bus.ans_suma;
         OP_RESTA: ans_sel = bus.ans_resta;
         OP_AND:   ans_sel = bus.ans_and;
         OP_OR:    ans_sel = bus.ans_or;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ultimo_d     = ultimo_q;
      cnt_d        = cnt_q;
      reg0_d       = reg0_q;
      reg1_d       = reg1_q;
      op_d         = op_q;
      id_d         = id_q;
      resp_valid_d = resp_valid_q;
      resp_dato_d  = resp_dato_q;
      resp_id_d    = resp_id_q;
      resp_cero_d  = resp_cero_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      en_unidad    = 4'b0000;

      unique case (state_q)
         StIdle: begin
            // Grant implies the matching valid, so a grant is a handshake.
            if (!rst && (grant != 2'b00)) begin
               req0_ready = grant[0];
               req1_ready = grant[1];
               reg0_d     = grant_id ? bus.req1_a  : bus.req0_a;
               reg1_d     = grant_id ? bus.req1_b  : bus.req0_b;
               op_d       = grant_id ? bus.req1_op : bus.req0_op;
               id_d       = grant_id;
               state_d    = StExec;
            end
         end
         StExec: begin
            en_unidad = op_onehot(op_q);
            cnt_d     = CntW'(LAT - 1);
            state_d   = StEspera;
         end
         StEspera: begin
            if (cnt_q == '0) begin
               resp_dato_d  = ans_sel;
               resp_cero_d  = (ans_sel == '0);
               resp_id_d    = id_q;
               resp_valid_d = 1'b1;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               ultimo_d     = resp_id_q;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ultimo_q     <= 1'b1;
         cnt_q        <= '0;
         reg0_q       <= '0;
         reg1_q       <= '0;
         op_q         <= 2'b00;
         id_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_dato_q  <= '0;
         resp_id_q    <= 1'b0;
         resp_cero_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ultimo_q     <= ultimo_d;
         cnt_q        <= cnt_d;
         reg0_q       <= reg0_d;
         reg1_q       <= reg1_d;
         op_q         <= op_d;
         id_q         <= id_d;
         resp_valid_q <= resp_valid_d;
         resp_dato_q  <= resp_dato_d;
         resp_id_q    <= resp_id_d;
         resp_cero_q  <= resp_cero_d;
      end
   end

   assign bus.req0_ready = req0_ready;
   assign bus.req1_ready = req1_ready;
   assign bus.en_unidad  = en_unidad;
   assign bus.reg0       = reg0_q;
   assign bus.reg1       = reg1_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_dato  = resp_dato_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_cero  = resp_cero_q;

endmodule

// File: tb/tb_control_alu.sv
// Self-checking bench for control_alu: randomized requests against a behavioural
// model of arbitration and arithmetic, plus an LAT=3 instance for timing.
module tb_control_alu;
   import alu_pkg::*;

   localparam int unsigned W   = 4;
   localparam int unsigned LAT = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   control_alu_if #(.W(W)) bus ();
   control_alu_if #(.W(W)) bus3 ();

   control_alu #(.W(W), .LAT(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   control_alu #(.W(W), .LAT(3)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   // Registered units for the main instance: result appears the cycle after enable.
   always_ff @(posedge clk) begin
      if (bus.en_unidad[0]) bus.ans_suma  <= bus.reg0 + bus.reg1;
      if (bus.en_unidad[1]) bus.ans_resta <= bus.reg0 - bus.reg1;
      if (bus.en_unidad[2]) bus.ans_and   <= bus.reg0 & bus.reg1;
      if (bus.en_unidad[3]) bus.ans_or    <= bus.reg0 | bus.reg1;
   end

   int n_checks = 0;
   int n_pass   = 0;
   bit last_id  = 1'b1;

   function automatic logic [W-1:0] model_alu(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      int ia, ib, r, m;
      ia = int'(a);
      ib = int'(b);
      m  = 1 << W;
      case (op)
         2'd0:    r = (ia + ib) % m;
         2'd1:    r = (ia - ib + m) % m;
         2'd2:    r = ia & ib;
         default: r = ia | ib;
      endcase
      return r[W-1:0];
   endfunction

   function automatic bit model_grant(input bit v0, input bit v1);
      if (v0 && v1) return !last_id;
      return v1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input bit id, input bit v, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      if (id) begin
         bus.req1_valid = v;
         bus.req1_op    = op;
         bus.req1_a     = a;
         bus.req1_b     = b;
      end else begin
         bus.req0_valid = v;
         bus.req0_op    = op;
         bus.req0_a     = a;
         bus.req0_b     = b;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_id = 1'b1;
   endtask

   // Issues one op from requester id (the model's expected grantee) and follows it
   // through to the response handshake.
   task automatic run_op(input bit id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int stall);
      logic [W-1:0] exp;
      logic [1:0]   rdy;
      int           lat;
      exp = model_alu(op, a, b);
      drive_req(id, 1'b1, op, a, b);
      #1;
      rdy = {bus.req1_ready, bus.req0_ready};
      n_checks++;
      if (rdy !== (id ? 2'b10 : 2'b01))
         $display("FAIL grant: ready=%b expected=%b", rdy, (id ? 2'b10 : 2'b01));
      else n_pass++;

      tick();
      drive_req(id, 1'b0, 2'($urandom), W'($urandom), W'($urandom));
      #1;
      rdy = {bus.req1_ready, bus.req0_ready};
      n_checks++;
      if ({bus.reg0, bus.reg1} !== {a, b})
         $display("FAIL operands: reg0=%h reg1=%h expected %h %h", bus.reg0, bus.reg1, a, b);
      else n_pass++;
      n_checks++;
      if (bus.en_unidad !== 4'(1 << op) || rdy !== 2'b00)
         $display("FAIL enable: en=%b ready=%b expected en=%b ready=00", bus.en_unidad, rdy,
                  4'(1 << op));
      else n_pass++;

      lat = 0;
      while (bus.resp_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== int'(LAT) + 1)
         $display("FAIL latency: cycles=%0d expected=%0d", lat, int'(LAT) + 1);
      else n_pass++;
      n_checks++;
      if ({bus.resp_dato, bus.resp_id, bus.resp_cero} !== {exp, id, (exp == '0)})
         $display("FAIL response: dato=%h id=%b cero=%b expected %h %b %b", bus.resp_dato,
                  bus.resp_id, bus.resp_cero, exp, id, (exp == '0));
      else n_pass++;

      for (int i = 0; i < stall; i++) begin
         tick();
         rdy = {bus.req1_ready, bus.req0_ready};
         n_checks++;
         if ({bus.resp_valid, bus.resp_dato, bus.resp_id, rdy, bus.en_unidad} !==
             {1'b1, exp, id, 2'b00, 4'b0000})
            $display("FAIL hold: valid=%b dato=%h id=%b ready=%b en=%b expected 1 %h %b 00 0000",
                     bus.resp_valid, bus.resp_dato, bus.resp_id, rdy, bus.en_unidad, exp, id);
         else n_pass++;
      end

      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      n_checks++;
      if (bus.resp_valid !== 1'b0)
         $display("FAIL resp_done: resp_valid=%b expected=0", bus.resp_valid);
      else n_pass++;
      last_id = id;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_req(1'b0, 1'b1, 2'($urandom), W'($urandom), W'($urandom));
      drive_req(1'b1, 1'b1, 2'($urandom), W'($urandom), W'($urandom));
      tick();
      tick();
      n_checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
         $display("FAIL reset_ready: ready=%b expected=00", {bus.req1_ready, bus.req0_ready});
      else n_pass++;
      n_checks++;
      if ({bus.reg0, bus.reg1, bus.en_unidad} !== '0)
         $display("FAIL reset_regs: reg0=%h reg1=%h en=%b expected 0", bus.reg0, bus.reg1,
                  bus.en_unidad);
      else n_pass++;
      n_checks++;
      if ({bus.resp_valid, bus.resp_dato, bus.resp_id, bus.resp_cero} !== '0)
         $display("FAIL reset_resp: valid=%b dato=%h id=%b cero=%b expected 0", bus.resp_valid,
                  bus.resp_dato, bus.resp_id, bus.resp_cero);
      else n_pass++;
      drive_req(1'b0, 1'b0, 2'b00, '0, '0);
      drive_req(1'b1, 1'b0, 2'b00, '0, '0);
      rst = 1'b0;
      last_id = 1'b1;
   endtask

   task automatic test_basic_suma();
      run_op(1'b0, OP_SUMA, W'(3), W'(4), 0);
   endtask

   task automatic test_contention();
      bit g;
      apply_reset();
      drive_req(1'b1, 1'b1, OP_RESTA, W'(5), W'(5));
      g = model_grant(1'b1, 1'b1);
      run_op(g, 2'($urandom), W'($urandom), W'($urandom), 1);
      g = model_grant(1'b0, 1'b1);
      run_op(g, OP_RESTA, W'(5), W'(5), 0);
      drive_req(1'b1, 1'b1, 2'($urandom), W'($urandom), W'($urandom));
      g = model_grant(1'b1, 1'b1);
      run_op(g, 2'($urandom), W'($urandom), W'($urandom), 0);
      drive_req(!g, 1'b0, 2'b00, '0, '0);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      run_op(1'b0, 2'($urandom), a, b, 5);
      tick();
      tick();
      n_checks++;
      if ({bus.reg0, bus.reg1} !== {a, b})
         $display("FAIL reg_hold: reg0=%h reg1=%h expected %h %h", bus.reg0, bus.reg1, a, b);
      else n_pass++;
   endtask

   task automatic test_wrap();
      run_op(1'b1, OP_SUMA, W'(4'hF), W'(4'h2), 0);
      run_op(1'b1, OP_AND,  W'(4'hC), W'(4'hA), 0);
      run_op(1'b1, OP_OR,   W'(4'hC), W'(4'hA), 0);
   endtask

   task automatic test_random();
      logic [1:0] v;
      bit         g;
      for (int n = 0; n < 16; n++) begin
         v = 2'($urandom_range(1, 3));
         g = model_grant(v[0], v[1]);
         drive_req(!g, v[!g], 2'($urandom), W'($urandom), W'($urandom));
         run_op(g, 2'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 2));
         drive_req(!g, 1'b0, 2'b00, '0, '0);
      end
   endtask

   task automatic test_reset_exec();
      bit seen;
      drive_req(1'b0, 1'b1, OP_AND, W'($urandom), W'($urandom));
      #1;
      tick();
      drive_req(1'b0, 1'b0, 2'b00, '0, '0);
      #1;
      n_checks++;
      if (bus.en_unidad !== 4'b0100)
         $display("FAIL exec_en: en=%b expected=0100", bus.en_unidad);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++;
      if ({bus.reg0, bus.reg1, bus.en_unidad, bus.resp_valid, bus.resp_dato, bus.resp_id,
           bus.resp_cero, bus.req0_ready, bus.req1_ready} !== '0)
         $display("FAIL exec_reset: reg0=%h reg1=%h en=%b valid=%b dato=%h expected 0",
                  bus.reg0, bus.reg1, bus.en_unidad, bus.resp_valid, bus.resp_dato);
      else n_pass++;
      rst = 1'b0;
      last_id = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.resp_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) $display("FAIL abandoned_op: resp_valid rose=%b expected=0", seen);
      else n_pass++;
      run_op(1'b0, 2'($urandom), W'($urandom), W'($urandom), 0);
   endtask

   task automatic test_lat3();
      logic [W-1:0] base;
      logic [W-1:0] exp;
      base = W'($urandom);
      bus3.req0_valid = 1'b1;
      bus3.req0_op    = OP_SUMA;
      bus3.req0_a     = W'($urandom);
      bus3.req0_b     = W'($urandom);
      #1;
      n_checks++;
      if (bus3.req0_ready !== 1'b1)
         $display("FAIL lat3_ready: ready=%b expected=1", bus3.req0_ready);
      else n_pass++;
      tick();
      bus3.req0_valid = 1'b0;
      bus3.ans_suma   = base + W'(1);
      #1;
      n_checks++;
      if (bus3.en_unidad !== 4'b0001)
         $display("FAIL lat3_en: en=%b expected=0001", bus3.en_unidad);
      else n_pass++;
      for (int k = 2; k <= 5; k++) begin
         tick();
         bus3.ans_suma = base + W'(k);
         #1;
         if (k < 5) begin
            n_checks++;
            if (bus3.resp_valid !== 1'b0)
               $display("FAIL lat3_early: T%0d resp_valid=%b expected=0", k, bus3.resp_valid);
            else n_pass++;
         end
      end
      exp = base + W'(4);
      n_checks++;
      if ({bus3.resp_valid, bus3.resp_dato, bus3.resp_id} !== {1'b1, exp, 1'b0})
         $display("FAIL lat3_resp: valid=%b dato=%h id=%b expected 1 %h 0", bus3.resp_valid,
                  bus3.resp_dato, bus3.resp_id, exp);
      else n_pass++;
      bus3.resp_ready = 1'b1;
      tick();
      bus3.resp_ready = 1'b0;
      n_checks++;
      if (bus3.resp_valid !== 1'b0)
         $display("FAIL lat3_done: resp_valid=%b expected=0", bus3.resp_valid);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 2'b00, '0, '0);
      drive_req(1'b1, 1'b0, 2'b00, '0, '0);
      bus.resp_ready  = 1'b0;
      bus3.req0_valid = 1'b0;
      bus3.req0_op    = 2'b00;
      bus3.req0_a     = '0;
      bus3.req0_b     = '0;
      bus3.req1_valid = 1'b0;
      bus3.req1_op    = 2'b00;
      bus3.req1_a     = '0;
      bus3.req1_b     = '0;
      bus3.resp_ready = 1'b0;
      bus3.ans_suma   = '0;
      bus3.ans_resta  = '0;
      bus3.ans_and    = '0;
      bus3.ans_or     = '0;

      test_reset();
      test_basic_suma();
      test_contention();
      test_backpressure();
      test_wrap();
      test_random();
      test_reset_exec();
      test_lat3();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
